// File: rtl/nios_pio_frame_bank.sv
// Double-buffered Avalon-MM output bank: CPU writes shadow registers, and a
// frame tick commits every shadow value to the active outputs in one edge.
module nios_pio_frame_bank #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic                      frame_tick,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);

  localparam int unsigned CNT_W       = 16;
  localparam logic [4:0]  ADDR_CTRL   = 5'd16;
  localparam logic [4:0]  ADDR_STATUS = 5'd17;
  localparam logic [4:0]  ADDR_COUNT  = 5'd18;

  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];
  logic [WIDTH-1:0] active_d [CHANNELS];
  logic             auto_q, auto_d;
  logic             irq_en_q, irq_en_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic wr_en_c;
  logic commit_c;
  logic unused_wdata;

  // Bits of writedata above WIDTH are intentionally dropped.
  assign unused_wdata = ^writedata;

  assign wr_en_c  = chipselect && !write_n;
  assign commit_c = frame_tick && (pending_q || auto_q);

  // Next-state: commit uses pre-write shadow; new COMMIT and DONE-set win.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    done_d    = done_q;
    count_d   = count_q;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_en_c && (address == 5'(i))) begin
        shadow_d[i] = writedata[WIDTH-1:0];
      end
    end

    if (commit_c) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      count_d   = count_q + CNT_W'(1);
    end

    if (wr_en_c && (address == ADDR_CTRL)) begin
      auto_d   = writedata[1];
      irq_en_d = writedata[2];
      if (writedata[0]) begin
        pending_d = 1'b1;
      end
    end

    if (wr_en_c && (address == ADDR_STATUS) && writedata[1]) begin
      done_d = 1'b0;
    end
    if (commit_c) begin
      done_d = 1'b1;
    end

    irq_d = done_d && irq_en_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      count_q   <= count_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_out
      assign out_port[g*WIDTH +: WIDTH] = active_q[g];
    end
  endgenerate

  assign irq = irq_q;

  // Zero-latency read mux; driven to 0 whenever the slave is not selected.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (address == 5'(i)) begin
          readdata = 32'(shadow_q[i]);
        end
      end
      case (address)
        ADDR_CTRL:   readdata = {29'd0, irq_en_q, auto_q, 1'b0};
        ADDR_STATUS: readdata = {30'd0, done_q, pending_q};
        ADDR_COUNT:  readdata = {16'd0, count_q};
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_pio_frame_bank.sv
// Directed bench for nios_pio_frame_bank: default 8x20 instance against a
// behavioural model, plus 1x32 and 16x1 instances for the parameter corners.
module tb_nios_pio_frame_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   address;
  logic         cs0, cs1, cs2;
  logic         write_n;
  logic [31:0]  writedata;
  logic         frame_tick;
  logic [31:0]  rd0, rd1, rd2;
  logic [159:0] out0;
  logic [31:0]  out1;
  logic [15:0]  out2;
  logic         irq0, irq1, irq2;

  always #5 clk = ~clk;

  nios_pio_frame_bank #(.CHANNELS(8), .WIDTH(20)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .frame_tick(frame_tick), .out_port(out0), .irq(irq0));

  nios_pio_frame_bank #(.CHANNELS(1), .WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .frame_tick(frame_tick), .out_port(out1), .irq(irq1));

  nios_pio_frame_bank #(.CHANNELS(16), .WIDTH(1)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .frame_tick(frame_tick), .out_port(out2), .irq(irq2));

  int n_pass  = 0;
  int n_total = 0;
  logic [159:0] exp_q [$];

  // Reference model of the 8x20 instance
  logic [19:0] sh_m [8];
  logic [19:0] act_m [8];
  logic        pend_m, done_m, auto_m, irqen_m;
  logic [15:0] cnt_m;

  function automatic void check(string tag, logic [159:0] obs, logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endfunction

  function automatic void pop_check(string tag, logic [159:0] obs);
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    pend_m = 0; done_m = 0; auto_m = 0; irqen_m = 0; cnt_m = '0;
  endfunction

  function automatic void mstep(logic wr, logic [4:0] a, logic [31:0] d, logic tk);
    logic [19:0] old [8];
    logic commit, newreq;
    commit = tk && (pend_m || auto_m);
    old    = sh_m;
    newreq = 0;
    if (wr) begin
      if (a < 5'd8) sh_m[a[2:0]] = d[19:0];
      if (a == 5'd16) begin
        auto_m  = d[1];
        irqen_m = d[2];
        newreq  = d[0];
      end
      if (a == 5'd17 && d[1]) done_m = 0;
    end
    if (commit) begin
      act_m  = old;
      done_m = 1;
      cnt_m  = cnt_m + 16'd1;
      pend_m = newreq;
    end else if (newreq) begin
      pend_m = 1;
    end
  endfunction

  function automatic logic [31:0] mread(logic [4:0] a);
    if (a < 5'd8)   return {12'd0, sh_m[a[2:0]]};
    if (a == 5'd16) return {29'd0, irqen_m, auto_m, 1'b0};
    if (a == 5'd17) return {30'd0, done_m, pend_m};
    if (a == 5'd18) return {16'd0, cnt_m};
    return 32'd0;
  endfunction

  function automatic logic [159:0] mout();
    logic [159:0] v;
    for (int i = 0; i < 8; i++) v[i*20 +: 20] = act_m[i];
    return v;
  endfunction

  // Drive one bus cycle, sampled by the next rising edge
  task automatic cycle(input int sel, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic tk);
    @(negedge clk);
    cs0 = wr && (sel == 0);
    cs1 = wr && (sel == 1);
    cs2 = wr && (sel == 2);
    write_n    = !wr;
    address    = a;
    writedata  = d;
    frame_tick = tk;
    mstep(wr && (sel == 0), a, d, tk);
  endtask

  task automatic settle();
    cycle(0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
  endtask

  task automatic rd_expect(input int sel, input logic [4:0] a,
                           input logic [31:0] exp, input string tag);
    logic [31:0] obs;
    exp_q.push_back({128'd0, exp});
    @(negedge clk);
    cs0 = (sel == 0); cs1 = (sel == 1); cs2 = (sel == 2);
    write_n = 1'b1; address = a; writedata = '0; frame_tick = 1'b0;
    #1;
    obs = (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd2;
    cs0 = 0; cs1 = 0; cs2 = 0;
    pop_check(tag, {128'd0, obs});
  endtask

  task automatic out_expect(input string tag);
    exp_q.push_back(mout());
    settle();
    pop_check(tag, out0);
  endtask

  logic [15:0] pat;

  initial begin
    reset = 1'b1;
    cs0 = 0; cs1 = 0; cs2 = 0; write_n = 1'b1;
    address = '0; writedata = '0; frame_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_out", out0, 160'd0);
    check("rst_irq", {159'd0, irq0}, 160'd0);
    rd_expect(0, 5'd16, 32'd0, "rst_ctrl");
    rd_expect(0, 5'd17, 32'd0, "rst_status");
    rd_expect(0, 5'd18, 32'd0, "rst_count");

    // Shadow write is not visible until a commit
    cycle(0, 1, 5'd3, 32'h0001_2345, 0);
    rd_expect(0, 5'd3, 32'h0001_2345, "sh3_read");
    out_expect("sh3_not_active");
    check("out_still_zero", out0, 160'd0);

    // One-shot commit
    cycle(0, 1, 5'd16, 32'h1, 0);
    rd_expect(0, 5'd16, 32'h0, "ctrl_commit_reads0");
    rd_expect(0, 5'd17, 32'h1, "pending_set");
    cycle(0, 0, 5'd0, 32'd0, 1);
    out_expect("commit_out");
    check("ch3_slice", {140'd0, out0[79:60]}, 160'h12345);
    rd_expect(0, 5'd18, 32'h1, "count_1");
    rd_expect(0, 5'd17, 32'h2, "done_nopend");

    // Tick with nothing pending changes nothing
    cycle(0, 0, 5'd0, 32'd0, 1);
    out_expect("idle_tick_out");
    rd_expect(0, 5'd18, mread(5'd18), "idle_tick_count");

    // Shadow write in the commit cycle: active takes the old value
    cycle(0, 1, 5'd0, 32'hA, 0);
    cycle(0, 1, 5'd16, 32'h1, 0);
    cycle(0, 1, 5'd0, 32'hB, 1);
    settle();
    check("same_cyc_active", {140'd0, out0[19:0]}, 160'hA);
    rd_expect(0, 5'd0, 32'hB, "same_cyc_shadow");
    cycle(0, 1, 5'd16, 32'h1, 0);
    cycle(0, 0, 5'd0, 32'd0, 1);
    settle();
    check("second_commit", {140'd0, out0[19:0]}, 160'hB);
    rd_expect(0, 5'd18, 32'h3, "count_3");

    // Repeated COMMIT writes fold into one commit
    repeat (3) cycle(0, 1, 5'd16, 32'h1, 0);
    cycle(0, 0, 5'd0, 32'd0, 1);
    rd_expect(0, 5'd18, 32'h4, "count_once");
    cycle(0, 0, 5'd0, 32'd0, 1);
    rd_expect(0, 5'd18, 32'h4, "count_no_retrigger");

    // COMMIT write during a commit stays pending for the next tick
    cycle(0, 1, 5'd16, 32'h1, 0);
    cycle(0, 1, 5'd16, 32'h1, 1);
    rd_expect(0, 5'd17, 32'h3, "pend_survives");
    cycle(0, 0, 5'd0, 32'd0, 1);
    rd_expect(0, 5'd18, mread(5'd18), "pend_fires");
    rd_expect(0, 5'd17, 32'h2, "pend_cleared");

    // Interrupt
    cycle(0, 1, 5'd16, 32'h4, 0);
    cycle(0, 1, 5'd17, 32'h2, 0);
    settle();
    check("irq_cleared", {159'd0, irq0}, 160'd0);
    cycle(0, 1, 5'd16, 32'h5, 0);
    cycle(0, 0, 5'd0, 32'd0, 1);
    settle();
    check("irq_on_commit", {159'd0, irq0}, 160'd1);
    cycle(0, 1, 5'd17, 32'h2, 0);
    settle();
    check("irq_w1c", {159'd0, irq0}, 160'd0);
    cycle(0, 1, 5'd16, 32'h5, 0);
    cycle(0, 1, 5'd17, 32'h2, 1);
    settle();
    check("irq_set_wins", {159'd0, irq0}, {159'd0, done_m && irqen_m});
    rd_expect(0, 5'd17, 32'h2, "done_set_wins");

    // Unselected slave drives zero
    @(negedge clk);
    cs0 = 0; write_n = 1'b1; address = 5'd16; frame_tick = 0;
    #1;
    check("rd_no_cs", {128'd0, rd0}, 160'd0);

    // Reserved addresses
    cycle(0, 1, 5'd10, 32'hFFFF_FFFF, 0);
    cycle(0, 1, 5'd25, 32'hFFFF_FFFF, 0);
    rd_expect(0, 5'd10, 32'd0, "resv10");
    rd_expect(0, 5'd25, 32'd0, "resv25");
    rd_expect(0, 5'd19, 32'd0, "resv19");
    rd_expect(0, 5'd0, mread(5'd0), "resv_sh0");
    rd_expect(0, 5'd16, mread(5'd16), "resv_ctrl");
    out_expect("resv_out");

    // Asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_out", out0, 160'd0);
    check("async_irq", {159'd0, irq0}, 160'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rd_expect(0, 5'd18, 32'd0, "async_count");

    // AUTO mode: 65537 consecutive ticks wrap COUNT to 1
    cycle(0, 1, 5'd16, 32'h2, 0);
    for (int k = 0; k < 65537; k++) begin
      if (k == 1 || k == 101 || k == 102 || k == 65536) exp_q.push_back(mout());
      if (k == 100) cycle(0, 1, 5'd3, 32'h5_5555, 1);
      else          cycle(0, 0, 5'd0, 32'd0, 1);
      if (k == 1 || k == 101 || k == 102 || k == 65536) pop_check("auto_track", out0);
    end
    rd_expect(0, 5'd18, 32'h1, "count_wrap");
    check("auto_ch3", {140'd0, out0[79:60]}, 160'h55555);

    // 1 x 32 instance
    cycle(1, 1, 5'd0, 32'hDEAD_BEEF, 0);
    cycle(1, 1, 5'd1, 32'hFFFF_FFFF, 0);
    rd_expect(1, 5'd0, 32'hDEAD_BEEF, "w32_read");
    rd_expect(1, 5'd1, 32'd0, "w32_resv");
    settle();
    check("w32_pre", {128'd0, out1}, 160'd0);
    cycle(1, 1, 5'd16, 32'h1, 0);
    cycle(1, 0, 5'd0, 32'd0, 1);
    settle();
    check("w32_out", {128'd0, out1}, {128'd0, 32'hDEAD_BEEF});
    check("w32_irq", {159'd0, irq1}, 160'd0);
    rd_expect(1, 5'd18, 32'h1, "w32_count");

    // 16 x 1 instance: upper writedata bits are dropped
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) cycle(2, 1, 5'(i), {31'h7FFF_FFFF, pat[i]}, 0);
    rd_expect(2, 5'd0, {31'd0, pat[0]}, "w1_rd0");
    rd_expect(2, 5'd2, {31'd0, pat[2]}, "w1_rd2");
    rd_expect(2, 5'd15, {31'd0, pat[15]}, "w1_rd15");
    cycle(2, 1, 5'd16, 32'h1, 0);
    cycle(2, 0, 5'd0, 32'd0, 1);
    settle();
    check("w1_out", {144'd0, out2}, {144'd0, pat});
    check("w1_irq", {159'd0, irq2}, 160'd0);
    rd_expect(2, 5'd17, 32'h2, "w1_status");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
